// File: rtl/dcache_assoc_if.sv
// CPU load/store and memory req/ack bundle for dcache_assoc.
// The cache owns the slave modport; the CPU/memory side owns master.
interface dcache_assoc_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_rd;
  logic [3:0]        cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate, set-associative data cache, one 32-bit word per line.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_assoc #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8,
  parameter int WAYS    = 2
) (
  input  logic          clk,
  input  logic          rst,
  dcache_assoc_if.slave bus,
  output logic          hit,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

  state_t             state;
  logic [31:0]        data_q  [WAYS][SETS];
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [WAY_W-1:0]   ptr_q   [SETS];

  logic [INDEX_W-1:0] r_idx;
  logic [TAG_W-1:0]   r_tag;
  logic [3:0]         r_wr;
  logic [31:0]        r_wdata, r_rdata;
  logic [WAY_W-1:0]   r_way;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               is_store, is_req, any_hit, any_inv, vict_dirty, refill_done;
  logic [WAY_W-1:0]   hit_way, inv_way, victim;
  logic [31:0]        fill_word;
  logic               line_we, tag_we;
  logic [WAY_W-1:0]   line_way;
  logic [INDEX_W-1:0] line_idx;
  logic [31:0]        line_data;
  logic               unused_ok;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign req_idx   = bus.cpu_addr[INDEX_W+1:2];
  assign req_tag   = bus.cpu_addr[ADDR_W-1:INDEX_W+2];
  assign unused_ok = ^bus.cpu_addr[1:0];
  assign is_store  = |bus.cpu_wr;
  // The CPU still holds the finished request during the ready pulse; ignore it then.
  assign is_req    = (bus.cpu_rd | is_store) & ~bus.cpu_ready;

  always_comb begin
    any_hit = 1'b0;
    any_inv = 1'b0;
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim      = any_inv ? inv_way : ((WAYS == 1) ? '0 : ptr_q[req_idx]);
  assign vict_dirty  = valid_q[req_idx][victim] & dirty_q[req_idx][victim];
  assign hit         = (state == IDLE) & is_req & any_hit;
  assign refill_done = (state == REFILL) & ((r_wr == 4'hF) | (bus.mem_req & bus.mem_ack));
  assign fill_word   = (r_wr == 4'hF) ? r_wdata : merge(bus.mem_rdata, r_wdata, r_wr);

  always_comb begin
    line_we   = 1'b0;
    tag_we    = 1'b0;
    line_way  = hit_way;
    line_idx  = req_idx;
    line_data = merge(data_q[hit_way][req_idx], bus.cpu_wdata, bus.cpu_wr);
    if (rst && hit && is_store) line_we = 1'b1;
    if (rst && refill_done) begin
      line_we   = 1'b1;
      tag_we    = 1'b1;
      line_way  = r_way;
      line_idx  = r_idx;
      line_data = fill_word;
    end
  end

  // Line storage survives reset; valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[line_way][line_idx] <= line_data;
      if (tag_we) tag_q[line_way][line_idx] <= r_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      r_idx         <= '0;
      r_tag         <= '0;
      r_wr          <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_way         <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      case (state)
        IDLE: if (is_req) begin
          r_idx   <= req_idx;
          r_tag   <= req_tag;
          r_wr    <= bus.cpu_wr;
          r_wdata <= bus.cpu_wdata;
          if (any_hit) begin
            if (is_store) dirty_q[req_idx][hit_way] <= 1'b1;
            r_rdata <= data_q[hit_way][req_idx];
            state   <= DONE;
          end else begin
            r_way <= victim;
            if (vict_dirty) begin
              state         <= WB;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {tag_q[victim][req_idx], req_idx, 2'b00};
              bus.mem_wdata <= data_q[victim][req_idx];
            end else begin
              state <= REFILL;
              if (bus.cpu_wr != 4'hF) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= {req_tag, req_idx, 2'b00};
              end
            end
          end
        end
        // mem_req drops for a cycle between write-back and refill so each
        // transaction starts with a fresh rising request.
        WB: if (bus.mem_ack) begin
          valid_q[r_idx][r_way] <= 1'b0;
          dirty_q[r_idx][r_way] <= 1'b0;
          bus.mem_req           <= 1'b0;
          bus.mem_we            <= 1'b0;
          bus.mem_wdata         <= '0;
          state                 <= REFILL;
        end
        REFILL: begin
          if (refill_done) begin
            valid_q[r_idx][r_way] <= 1'b1;
            dirty_q[r_idx][r_way] <= |r_wr;
            ptr_q[r_idx]          <= (WAYS == 1) ? '0 : r_way + 1'b1;
            r_rdata               <= bus.mem_rdata;
            bus.mem_req           <= 1'b0;
            state                 <= DONE;
          end else if (!bus.mem_req) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {r_tag, r_idx, 2'b00};
          end
        end
        DONE: begin
          bus.cpu_ready <= 1'b1;
          bus.cpu_rdata <= (r_wr == 4'h0) ? r_rdata : '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && is_req) begin
      if (any_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else if (miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule
